muxn_skid: RTL

//   Parametrised N-input operand selector with a registered, flow-controlled output stage.

---
 rtl/muxn_skid.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/muxn_skid.sv
// -----------------------------------------------------------------------------
// muxn_skid
//   N-input operand selector followed by a 2-entry skid buffer. One of N
//   WIDTH-bit inputs is picked per accepted transfer. The selection is
//   combinational, so the chosen word goes straight into the buffer register
//   and adds no latency of its own. The buffer is a head (main) entry plus a
//   skid entry, which lets the input side keep a registered in_ready without
//   ever dropping a word offered in the cycle the output stalls.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   - Input side : accept = in_valid && in_ready. in_data and sel are sampled
//                  together on accept. in_ready is a register and does not
//                  depend on in_valid in the same cycle.
//   - Output side: pop = out_valid && out_ready. While out_valid && !out_ready,
//                  out_data / out_selerr / out_valid hold steady.
//   flush discards every buffered entry and the word offered in that cycle.
//   It has priority over accept and pop.
//
// Parameters:
//   WIDTH  data width of each input and of out_data
//   N      number of selectable inputs (N >= 2)
//   SELW   width of sel, derived as $clog2(N); not overridable
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_data     flat inputs, input k = in_data[k*WIDTH +: WIDTH]
//   sel         input index; sel >= N picks input 0 and flags out_selerr
//   in_valid    upstream offers in_data/sel
//   in_ready    block can accept this cycle (registered)
//   flush       synchronous discard of all buffered entries
//   out_data    data of the head entry
//   out_selerr  head entry was selected with an out-of-range sel
//   out_valid   head entry valid
//   out_ready   downstream consumes the head entry
//   occ         number of buffered entries (0..2); also the FSM state code
// -----------------------------------------------------------------------------
module muxn_skid #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_selerr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           occ
);

  // ---------------------------------------------------------------------------
  // Buffer state. The state code equals the number of valid entries, so occ
  // is the FSM state itself and doubles as its debug view.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   head_data;
  logic               head_err;
  logic [WIDTH-1:0]   skid_data;
  logic               skid_err;
  logic               in_ready_q;

  // ---------------------------------------------------------------------------
  // Operand selection. If no input index matches sel, the word falls back to
  // input 0 with the error flag set. When N is a power of two every sel value
  // matches, so the error path is never taken.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   pick_data;
  logic               pick_err;

  always_comb begin
    pick_data = in_data[WIDTH-1:0];
    pick_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        pick_data = in_data[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake events for this cycle.
  // ---------------------------------------------------------------------------
  logic accept;
  logic pop;

  assign accept = in_valid && in_ready_q;
  assign pop    = (state != S_EMPTY) && out_ready;

  // ---------------------------------------------------------------------------
  // Buffer FSM with registered in_ready.
  // in_ready is loaded with (next occupancy < 2). It therefore drops on the
  // same edge that fills the buffer. It is 1 in ONE, so an accept without a
  // pop in ONE always has the skid entry free to absorb it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_EMPTY;
      head_data  <= '0;
      head_err   <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      in_ready_q <= 1'b0;
    end else if (flush) begin
      // Entries are dropped by clearing the state only. The data registers
      // keep stale contents, which is harmless while out_valid is 0.
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            head_data <= pick_data;
            head_err  <= pick_err;
            state     <= S_ONE;
          end
          in_ready_q <= 1'b1;
        end

        S_ONE: begin
          if (accept && pop) begin
            // Head leaves and the new word takes its place at once.
            head_data  <= pick_data;
            head_err   <= pick_err;
            in_ready_q <= 1'b1;
          end else if (accept) begin
            // Head is stalled, so the new word parks in the skid entry.
            skid_data  <= pick_data;
            skid_err   <= pick_err;
            state      <= S_FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        S_FULL: begin
          // in_ready is 0 here, so no accept can occur. Only a pop moves us.
          if (pop) begin
            head_data  <= skid_data;
            head_err   <= skid_err;
            state      <= S_ONE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end

        default: begin
          state      <= S_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all driven from registers.
  // ---------------------------------------------------------------------------
  assign in_ready   = in_ready_q;
  assign out_data   = head_data;
  assign out_selerr = head_err;
  assign out_valid  = (state != S_EMPTY);
  assign occ        = state;

endmodule
